// File: rtl/b01_serial_sched.sv
// Round-robin front end and bit-serial sequencer for a b01-class unit:
// grants one of two requesters, streams operands LSB-first and rebuilds the OUTP word.
module b01_serial_sched #(
  parameter int W = 8
) (
  input  logic         CLOCK,
  input  logic         RESET_N,
  input  logic         REQ0_VALID,
  input  logic [W-1:0] REQ0_A,
  input  logic [W-1:0] REQ0_B,
  output logic         REQ0_READY,
  input  logic         REQ1_VALID,
  input  logic [W-1:0] REQ1_A,
  input  logic [W-1:0] REQ1_B,
  output logic         REQ1_READY,
  output logic         RSP_VALID,
  input  logic         RSP_READY,
  output logic         RSP_ID,
  output logic [W-1:0] RSP_SUM,
  output logic         RSP_OVF,
  output logic         CORE_CLR,
  output logic         CORE_EN,
  output logic         LINE1,
  output logic         LINE2,
  input  logic         OUTP,
  input  logic         OVERFLW,
  output logic         BUSY
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t        state_r, state_nxt_s;
  logic          last_r, last_nxt_s;
  logic          id_r, id_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [W-1:0]  a_sh_r, a_sh_nxt_s;
  logic [W-1:0]  b_sh_r, b_sh_nxt_s;
  logic [W-1:0]  res_r, res_nxt_s;
  logic [W-1:0]  capture_s;
  logic          ovf_r, ovf_nxt_s;
  logic          grant0_s, grant1_s;
  logic          core_clr_r, core_en_r, line1_r, line2_r, rsp_valid_r, busy_r;

  // Arbitration: on a tie the requester that did not win last time gets the unit.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (RESET_N && (state_r == IDLE)) begin
      if (REQ0_VALID && REQ1_VALID) begin
        grant0_s = last_r;
        grant1_s = ~last_r;
      end else if (REQ0_VALID) begin
        grant0_s = 1'b1;
      end else if (REQ1_VALID) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Result reassembly: OUTP enters at the MSB so the first captured bit ends at bit 0.
  always_comb begin
    capture_s        = res_r >> 1;
    capture_s[W-1]   = OUTP;
  end

  // Next-state and datapath update for the whole operation sequence.
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    id_nxt_s    = id_r;
    cnt_nxt_s   = cnt_r;
    a_sh_nxt_s  = a_sh_r;
    b_sh_nxt_s  = b_sh_r;
    res_nxt_s   = res_r;
    ovf_nxt_s   = ovf_r;
    case (state_r)
      IDLE: begin
        if (grant0_s || grant1_s) begin
          a_sh_nxt_s  = grant1_s ? REQ1_A : REQ0_A;
          b_sh_nxt_s  = grant1_s ? REQ1_B : REQ0_B;
          id_nxt_s    = grant1_s;
          last_nxt_s  = grant1_s;
          state_nxt_s = CLR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLR: begin
        cnt_nxt_s   = '0;
        res_nxt_s   = '0;
        state_nxt_s = SHIFT;
      end
      SHIFT: begin
        a_sh_nxt_s = a_sh_r >> 1;
        b_sh_nxt_s = b_sh_r >> 1;
        // The unit's output lags the driven bit by one cycle, so cycle 0 has nothing to take.
        if (cnt_r != '0) begin
          res_nxt_s = capture_s;
        end else begin
          res_nxt_s = res_r;
        end
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = DRAIN;
        end else begin
          cnt_nxt_s   = cnt_r + CW'(1);
          state_nxt_s = SHIFT;
        end
      end
      DRAIN: begin
        res_nxt_s   = capture_s;
        ovf_nxt_s   = OVERFLW;
        state_nxt_s = RESP;
      end
      RESP: begin
        if (RSP_READY) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so they align with it.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_r     <= IDLE;
      last_r      <= 1'b1;
      id_r        <= 1'b0;
      cnt_r       <= '0;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      res_r       <= '0;
      ovf_r       <= 1'b0;
      core_clr_r  <= 1'b0;
      core_en_r   <= 1'b0;
      line1_r     <= 1'b0;
      line2_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      last_r      <= last_nxt_s;
      id_r        <= id_nxt_s;
      cnt_r       <= cnt_nxt_s;
      a_sh_r      <= a_sh_nxt_s;
      b_sh_r      <= b_sh_nxt_s;
      res_r       <= res_nxt_s;
      ovf_r       <= ovf_nxt_s;
      core_clr_r  <= (state_nxt_s == CLR);
      core_en_r   <= (state_nxt_s == SHIFT);
      line1_r     <= (state_nxt_s == SHIFT) ? a_sh_nxt_s[0] : 1'b0;
      line2_r     <= (state_nxt_s == SHIFT) ? b_sh_nxt_s[0] : 1'b0;
      rsp_valid_r <= (state_nxt_s == RESP);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  assign REQ0_READY = grant0_s;
  assign REQ1_READY = grant1_s;
  assign RSP_VALID  = rsp_valid_r;
  assign RSP_ID     = id_r;
  assign RSP_SUM    = res_r;
  assign RSP_OVF    = ovf_r;
  assign CORE_CLR   = core_clr_r;
  assign CORE_EN    = core_en_r;
  assign LINE1      = line1_r;
  assign LINE2      = line2_r;
  assign BUSY       = busy_r;

endmodule

// File: tb/tb_b01_serial_sched.sv
// Scoreboard bench for b01_serial_sched: W=8 and W=1 instances, each driving a registered full-adder stub.
module tb_b01_serial_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b, rsp_sum;
  logic rsp_valid, rsp_ready, rsp_id, rsp_ovf;
  logic core_clr, core_en, line1, line2, outp, ovfl, busy;

  logic w1_valid, w1_ready, w1_r1_ready, w1_rsp_valid, w1_rsp_id, w1_rsp_ovf;
  logic [0:0] w1_a, w1_b, w1_sum, w1_zero;
  logic w1_clr, w1_en, w1_l1, w1_l2, w1_outp, w1_ovfl, w1_busy;

  b01_serial_sched #(.W(8)) dut (
    .CLOCK(clk), .RESET_N(rst_n),
    .REQ0_VALID(req0_valid), .REQ0_A(req0_a), .REQ0_B(req0_b), .REQ0_READY(req0_ready),
    .REQ1_VALID(req1_valid), .REQ1_A(req1_a), .REQ1_B(req1_b), .REQ1_READY(req1_ready),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_ID(rsp_id), .RSP_SUM(rsp_sum),
    .RSP_OVF(rsp_ovf), .CORE_CLR(core_clr), .CORE_EN(core_en), .LINE1(line1), .LINE2(line2),
    .OUTP(outp), .OVERFLW(ovfl), .BUSY(busy)
  );

  b01_serial_sched #(.W(1)) dut_w1 (
    .CLOCK(clk), .RESET_N(rst_n),
    .REQ0_VALID(w1_valid), .REQ0_A(w1_a), .REQ0_B(w1_b), .REQ0_READY(w1_ready),
    .REQ1_VALID(1'b0), .REQ1_A(w1_zero), .REQ1_B(w1_zero), .REQ1_READY(w1_r1_ready),
    .RSP_VALID(w1_rsp_valid), .RSP_READY(1'b1), .RSP_ID(w1_rsp_id), .RSP_SUM(w1_sum),
    .RSP_OVF(w1_rsp_ovf), .CORE_CLR(w1_clr), .CORE_EN(w1_en), .LINE1(w1_l1), .LINE2(w1_l2),
    .OUTP(w1_outp), .OVERFLW(w1_ovfl), .BUSY(w1_busy)
  );

  // Registered full-adder stubs standing in for the serial unit.
  logic s_r, c_r, w1_s_r, w1_c_r;
  always @(posedge clk) begin
    if (core_clr) begin s_r <= 1'b0; c_r <= 1'b0; end
    else if (core_en) {c_r, s_r} <= {1'b0, line1} + {1'b0, line2} + {1'b0, c_r};
    if (w1_clr) begin w1_s_r <= 1'b0; w1_c_r <= 1'b0; end
    else if (w1_en) {w1_c_r, w1_s_r} <= {1'b0, w1_l1} + {1'b0, w1_l2} + {1'b0, w1_c_r};
  end
  assign outp = s_r;  assign ovfl = c_r;
  assign w1_outp = w1_s_r;  assign w1_ovfl = w1_c_r;
  assign w1_zero = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic id; logic [7:0] sum; logic ovf; } exp_t;
  exp_t exp_q[$];
  exp_t w1_q[$];
  exp_t mon_e, w1_e;

  // Monitors: pop an expectation on every response handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", rsp_id, mon_e.id);
        check("rsp_sum", rsp_sum, mon_e.sum);
        check("rsp_ovf", rsp_ovf, mon_e.ovf);
      end
    end
    if (rst_n && w1_rsp_valid) begin
      if (w1_q.size() == 0) check("w1_unexpected_rsp", 32'd1, 32'd0);
      else begin
        w1_e = w1_q.pop_front();
        check("w1_rsp_id", w1_rsp_id, w1_e.id);
        check("w1_rsp_sum", w1_sum, w1_e.sum);
        check("w1_rsp_ovf", w1_rsp_ovf, w1_e.ovf);
      end
    end
  end

  task automatic wait_grant(input bit which);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = which ? req1_ready : req0_ready;
      check("ready_exclusive", req0_ready & req1_ready, 32'd0);
    end
    check("grant_seen", got, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic watch(output int lat, output int clr_i, output int clr_n,
                       output int en_i, output int en_n, output logic [7:0] l1);
    lat = -1; clr_i = -1; clr_n = 0; en_i = -1; en_n = 0; l1 = 8'h00;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(negedge clk);
      if (core_clr) begin clr_n++; if (clr_i < 0) clr_i = i; end
      if (core_en) begin if (en_i < 0) en_i = i; if (en_n < 8) l1[en_n] = line1; en_n++; end
      if (rsp_valid) lat = i - 1;
    end
    if (lat < 0) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain_queue();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int lat, clr_i, clr_n, en_i, en_n, gcount, rcount, both_n;
  logic [7:0] l1;
  logic [3:0] gids;
  int rcyc[4];

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00;
    req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00;
    w1_valid = 1'b0; w1_a = 1'b0; w1_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 32'd0);
    check("rst_rsp_valid", rsp_valid, 32'd0);
    check("rst_core_en", core_en, 32'd0);
    check("rst_core_clr", core_clr, 32'd0);
    check("rst_line1", line1, 32'd0);
    check("rst_rsp_sum", rsp_sum, 32'd0);
    check("rst_rsp_ovf", rsp_ovf, 32'd0);
    check("rst_w1_busy", w1_busy, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single op from requester 0.
    rsp_ready = 1'b1;
    req0_a = 8'h5A; req0_b = 8'h3C; req0_valid = 1'b1;
    exp_q.push_back('{1'b0, 8'h96, 1'b0});
    wait_grant(1'b0);
    req0_valid = 1'b0;
    watch(lat, clr_i, clr_n, en_i, en_n, l1);
    check("t1_latency", lat, 32'd10);
    check("t1_line1_stream", l1, 32'h5A);
    check("t1_en_cycles", en_n, 32'd8);
    @(posedge clk); #1;

    // Single op from requester 1 with carry out.
    req1_a = 8'hFF; req1_b = 8'h01; req1_valid = 1'b1;
    exp_q.push_back('{1'b1, 8'h00, 1'b1});
    wait_grant(1'b1);
    req1_valid = 1'b0;
    watch(lat, clr_i, clr_n, en_i, en_n, l1);
    check("t2_clr_before_en", en_i, clr_i + 1);
    check("t2_clr_cycles", clr_n, 32'd1);
    check("t2_latency", lat, 32'd10);
    @(posedge clk); #1;

    // Both requesters held: alternating grants, W+4 spacing.
    req0_a = 8'h12; req0_b = 8'h34; req1_a = 8'h80; req1_b = 8'h80;
    req0_valid = 1'b1; req1_valid = 1'b1;
    gcount = 0; rcount = 0; both_n = 0; gids = 4'h0;
    for (int i = 0; i < 200 && rcount < 4; i++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) both_n++;
      if (gcount < 4 && (req0_ready || req1_ready)) begin
        gids[gcount] = req1_ready;
        if (req1_ready) exp_q.push_back('{1'b1, 8'h00, 1'b1});
        else exp_q.push_back('{1'b0, 8'h46, 1'b0});
        gcount++;
      end
      if (rsp_valid && rsp_ready) begin rcyc[rcount] = cyc; rcount++; end
      @(posedge clk); #1;
      if (gcount == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    check("t3_both_ready", both_n, 32'd0);
    check("t3_grant_order", gids, 32'b1010);
    check("t3_rsp_count", rcount, 32'd4);
    for (int k = 0; k < 3; k++) check("t3_rsp_spacing", rcyc[k+1] - rcyc[k], 32'd12);

    // Back-pressure in RESP while requester 0 waits.
    rsp_ready = 1'b0;
    req0_a = 8'h0F; req0_b = 8'h01; req0_valid = 1'b1;
    exp_q.push_back('{1'b0, 8'h10, 1'b0});
    wait_grant(1'b0);
    req0_a = 8'h21; req0_b = 8'h22;
    for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
    check("t4_rsp_seen", rsp_valid, 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("t4_stall_valid", rsp_valid, 32'd1);
      check("t4_stall_sum", rsp_sum, 32'h10);
      check("t4_stall_no_ready", req0_ready, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    exp_q.push_back('{1'b0, 8'h43, 1'b0});
    @(negedge clk);
    check("t4_no_grant_in_resp", req0_ready, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_grant_after_hs", req0_ready, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drain_queue();

    // Reset during SHIFT with counter at 3.
    req0_a = 8'hAA; req0_b = 8'h55; req0_valid = 1'b1;
    wait_grant(1'b0);
    req0_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("t5_pre_reset_shift", core_en, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_busy", busy, 32'd0);
    check("t5_core_en", core_en, 32'd0);
    check("t5_rsp_valid", rsp_valid, 32'd0);
    check("t5_line1", line1, 32'd0);
    @(posedge clk); #1;
    req0_a = 8'h11; req0_b = 8'h22; req1_a = 8'h44; req1_b = 8'h44;
    req0_valid = 1'b1; req1_valid = 1'b1;
    exp_q.push_back('{1'b0, 8'h33, 1'b0});
    wait_grant(1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain_queue();

    // W=1 instance: one SHIFT cycle, carry only.
    w1_a = 1'b1; w1_b = 1'b1; w1_valid = 1'b1;
    w1_q.push_back('{1'b0, 8'h00, 1'b1});
    for (int i = 0; i < 20 && !w1_ready; i++) @(negedge clk);
    check("t6_w1_grant", w1_ready, 32'd1);
    @(posedge clk); #1;
    w1_valid = 1'b0;
    lat = -1; en_n = 0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (w1_en) en_n++;
      if (w1_rsp_valid) lat = i - 1;
    end
    check("t6_w1_latency", lat, 32'd3);
    check("t6_w1_en_cycles", en_n, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("final_queue_empty", exp_q.size() + w1_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
